// File: rtl/rv_instr_encoder_if.sv
// Field-bundle input and encoded-word output bundle of the RV32I encoder.
// The slave modport is the encoder's view; master is the producer/consumer view.
interface rv_instr_encoder_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             err;
    logic [CNT_W-1:0] enc_count;

    modport slave (
        input  in_valid, op, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instr, err, enc_count
    );

    modport master (
        output in_valid, op, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instr, err, enc_count
    );
endinterface

// File: rtl/rv_instr_encoder.sv
// Sequential RV32I instruction encoder: packs decoded fields into machine
// words and queues them in a small output FIFO.
// Optional immediate range checking is enabled with macro RV_ENC_RANGE_CHECK_EN;
// without it, immediates are silently truncated to the format bits.
module rv_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    rv_instr_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

`ifdef RV_ENC_RANGE_CHECK_EN
    // True when the given upper slice is a pure sign extension.
    function automatic logic all_same(input logic [20:0] v, input logic [4:0] w);
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i < int'(w)) begin
                ones  = ones & v[i];
                zeros = zeros & ~v[i];
            end else begin
                ones  = ones;
                zeros = zeros;
            end
        end
        return ones | zeros;
    endfunction

    // True when the immediate fits the format selected by op/funct3.
    function automatic logic imm_fits(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [31:0] imm);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    ok = (imm[11:5] == 7'd0);
                end else begin
                    ok = all_same(imm[31:11], 5'd21);
                end
            end
            OP_LOAD, OP_JALR, OP_STORE: ok = all_same(imm[31:11], 5'd21);
            OP_BR:                      ok = all_same({1'b0, imm[31:12]}, 5'd20) & ~imm[0];
            OP_JAL:                     ok = all_same({9'd0, imm[31:20]}, 5'd12) & ~imm[0];
            OP_LUI, OP_AUIPC:           ok = (imm[11:0] == 12'd0);
            default:                    ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    logic [31:0]      word_s;
    logic             legal_s;
    logic             push_ok_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [OCC_W-1:0] occ_next_s;
    logic [OCC_W-1:0] occ_after_pop_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [31:0]      head_next_s;

    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [31:0]      instr_r;
    logic             err_r;
    logic [CNT_W-1:0] enc_count_r;

    // Pack the incoming field bundle into a machine word and flag legal opcodes.
    always_comb begin
        word_s  = 32'd0;
        legal_s = 1'b1;
        case (bus.op)
            OP_R: word_s = {1'b0, bus.funct7b5, 5'b00000, bus.rs2, bus.rs1,
                            bus.funct3, bus.rd, bus.op};
            OP_IMM: begin
                if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) begin
                    word_s = {1'b0, bus.funct7b5, 5'b00000, bus.imm[4:0], bus.rs1,
                              bus.funct3, bus.rd, bus.op};
                end else begin
                    word_s = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
                end
            end
            OP_LOAD:  word_s = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
            OP_JALR:  word_s = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, bus.op};
            OP_STORE: word_s = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                                bus.imm[4:0], bus.op};
            OP_BR:    word_s = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                bus.imm[4:1], bus.imm[11], bus.op};
            OP_LUI, OP_AUIPC: word_s = {bus.imm[31:12], bus.rd, bus.op};
            OP_JAL:   word_s = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                                bus.rd, bus.op};
            default:  legal_s = 1'b0;
        endcase
    end

    // Decide whether an accepted bundle becomes a FIFO word or an error pulse.
    always_comb begin
`ifdef RV_ENC_RANGE_CHECK_EN
        push_ok_s = legal_s & imm_fits(bus.op, bus.funct3, bus.imm);
`else
        push_ok_s = legal_s;
`endif
        accept_s = bus.in_valid & in_ready_r;
        push_s   = accept_s & push_ok_s;
        pop_s    = out_valid_r & bus.out_ready;
    end

    // Next occupancy, read pointer and head word after this cycle's push/pop.
    always_comb begin
        occ_next_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + OCC_W'(1);
            2'b01:   occ_next_s = occ_r - OCC_W'(1);
            default: occ_next_s = occ_r;
        endcase
        if (pop_s) begin
            occ_after_pop_s = occ_r - OCC_W'(1);
            rd_ptr_next_s   = rd_ptr_r + PTR_W'(1);
        end else begin
            occ_after_pop_s = occ_r;
            rd_ptr_next_s   = rd_ptr_r;
        end
        // A word pushed into an otherwise empty FIFO bypasses storage to the head.
        if (occ_next_s == OCC_W'(0)) begin
            head_next_s = 32'd0;
        end else if (occ_after_pop_s == OCC_W'(0)) begin
            head_next_s = word_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage write on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Pointers, occupancy, registered handshake/status outputs and word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            occ_r       <= OCC_W'(0);
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            instr_r     <= 32'd0;
            err_r       <= 1'b0;
            enc_count_r <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r    <= wr_ptr_r + PTR_W'(1);
                enc_count_r <= enc_count_r + CNT_W'(1);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            occ_r       <= occ_next_s;
            in_ready_r  <= (occ_next_s != OCC_W'(DEPTH));
            out_valid_r <= (occ_next_s != OCC_W'(0));
            instr_r     <= head_next_s;
            err_r       <= accept_s & ~push_ok_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.instr     = instr_r;
    assign bus.err       = err_r;
    assign bus.enc_count = enc_count_r;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: directed cases plus random bundles,
// checked against an arithmetic reference model of the RV32I formats.
module tb_rv_instr_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv_instr_encoder_if #(.CNT_W(CNT_W)) bus ();
    rv_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pushes = 0;
    logic [31:0] exp_q[$];
    int          err_q[$];
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: field placement by shifts and masks, ranges by signed value.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  output bit ok, output logic [31:0] w);
        longint si = longint'($signed(imm));
        logic [31:0] regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        bit fit = 1'b1;
        ok = 1'b1;
        w  = 32'd0;
        case (op)
            7'h33: w = (32'(f7) << 30) | regs | (32'(rd) << 7);
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w   = (32'(f7) << 30) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15)
                          | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
                    fit = ((imm >> 5) & 32'h7F) == 32'd0;
                end else begin
                    w   = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'(op)
                          | ((op == 7'h67) ? 32'd0 : (32'(f3) << 12));
                    fit = (si >= -2048) && (si <= 2047);
                end
            end
            7'h23: begin
                w   = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7);
                fit = (si >= -2048) && (si <= 2047);
            end
            7'h63: begin
                w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                fit = (si >= -4096) && (si <= 4095) && (imm % 2 == 0);
            end
            7'h37, 7'h17: begin
                w   = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
                fit = (imm & 32'hFFF) == 32'd0;
            end
            7'h6F: begin
                w   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7) | 32'(op);
                fit = (si >= -1048576) && (si <= 1048575) && (imm % 2 == 0);
            end
            default: ok = 1'b0;
        endcase
`ifdef RV_ENC_RANGE_CHECK_EN
        ok = ok && fit;
`else
        fit = fit;
`endif
    endfunction

    // Offer one bundle and wait (bounded) for acceptance; record expectations.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        bit ok;
        logic [31:0] w;
        int waited = 0;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model(op, f3, f7, rd, rs1, rs2, imm, ok, w);
                if (ok) begin
                    exp_q.push_back(w);
                    pushes++;
                end else begin
                    err_q.push_back(cyc + 1);
                end
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            waited++;
            if (waited > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
        end
    endtask

    // Wait (bounded) until every expected word and error pulse has been observed.
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare err and FIFO head against the scoreboard every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                bit exp_err;
                exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
                if (exp_err) void'(err_q.pop_front());
                check("err", 32'(bus.err), 32'(exp_err));
                if (bus.out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", bus.instr, 32'hxxxxxxxx);
                    end else begin
                        check("instr", bus.instr, exp_q[0]);
                        if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
                    end
                end else begin
                    check("idle_instr", bus.instr, 32'd0);
                end
            end
        end
    end

    // Random consumer back-pressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
        bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_enc_count", 32'(bus.enc_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // addi x1,x0,5 with one-cycle latency
        bus.out_ready = 1'b1;
        send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("addi_latency", 32'(bus.out_valid), 32'd1);
        check("addi_word", bus.instr, 32'h00500093);
        drain();
        check("addi_count", 32'(bus.enc_count), 32'd1);

        // add then sub back-to-back
        send(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        check("add_word", bus.instr, 32'h002081B3);
        send(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        check("sub_word", bus.instr, 32'h402081B3);
        // beq x1,x2,-8 and jal x1,+2048
        send(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8);
        check("beq_word", bus.instr, 32'hFE208CE3);
        send(7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        check("jal_word", bus.instr, 32'h001000EF);
        drain();

        // Fill the FIFO with the consumer stalled, then release it
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(7'h13, 3'd0, 1'b0, 5'(i + 4), 5'd1, 5'd0, 32'(i));
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(7'h13, 3'd0, 1'b0, 5'd9, 5'd1, 5'd0, 32'd9);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_hold_in_ready", 32'(bus.in_ready), 32'd0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                check("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
            end
        join
        drain();
        check("full_count", 32'(bus.enc_count), 32'(pushes));

        // Illegal opcode, out-of-range addi, shift, lui
        send(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(7'h13, 3'd5, 1'b1, 5'd2, 5'd3, 5'd0, 32'd7);
        send(7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        drain();
        check("illegal_count", 32'(bus.enc_count), 32'(pushes));

        // Asynchronous reset with two queued words
        bus.out_ready = 1'b0;
        send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        @(negedge clk); #2;
        reset = 1'b1;
        exp_q.delete(); err_q.delete(); pushes = 0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_instr", bus.instr, 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_enc_count", 32'(bus.enc_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(7'h23, 3'd2, 1'b0, 5'd0, 5'd4, 5'd5, 32'hFFFFFFFC);
        drain();
        check("post_rst_count", 32'(bus.enc_count), 32'd1);

        // Random bundles with random back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($signed(12'($urandom)));
                2:       imm = 32'($signed(13'($urandom))) & 32'hFFFFFFFE;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            send(ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), imm);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();
        check("rand_count", 32'(bus.enc_count), 32'(pushes % (1 << CNT_W)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Sequential RV32I instruction encoder; inverse of the main/ALU decode path.
- Accepts decoded fields (op, funct3, funct7b5, register indices, immediate) over a valid/ready handshake and packs them into 32-bit RV32I machine words.
- Words are queued in an output FIFO for the instruction-memory loader or a test-program generator.
- Words produced here must decode back to the same control signals in the single-cycle core.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 16, width of encoded-word counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
op  in  7  opcode
funct3  in  3  funct3 field
funct7b5  in  1  bit 30 selector (sub/sra/srai)
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  byte-offset/immediate, sign-extended value
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
instr  out  32  encoded word at FIFO head
err  out  1  one-cycle pulse: accepted bundle rejected
enc_count  out  CNT_W  words pushed since reset, wraps

Behaviour:
- Reset (async, active-high): FIFO empty, out_valid=0, in_ready=1, instr=0, err=0, enc_count=0. Applies mid-operation; queued words are discarded.
- in_ready = (FIFO occupancy < DEPTH), registered. There is no combinational path from out_ready.
- When full, in_ready=0 even if a pop occurs in the same cycle.
- Accept on in_valid && in_ready. The word is pushed at that edge. out_valid rises the next cycle when the FIFO was empty, giving 1-cycle latency.
- Pop on out_valid && out_ready. Simultaneous push and pop when not full keeps occupancy unchanged. Order is strictly FIFO. instr holds its value while out_valid && !out_ready.
- instr = 0 whenever out_valid = 0.
- Format by op:
  - R 0110011: {0,funct7b5,00000,rs2,rs1,funct3,rd,op}
  - I 0010011/0000011/1100111: {imm[11:0],rs1,funct3,rd,op}
    - JALR forces funct3=000.
    - Shifts (0010011, funct3 001/101): upper 7 bits = {0,funct7b5,00000}, imm[4:0] = shamt.
  - S 0100011: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
  - B 1100011: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}
  - U 0110111/0010111: {imm[31:12],rd,op}
  - J 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - Unused fields are ignored.
- Any other op: not pushed. err=1 for the cycle after acceptance. enc_count unchanged.
- enc_count increments on each push and wraps from 2^CNT_W-1 to 0.
- err and push are mutually exclusive per accepted bundle.

Optional Feature:
- Macro RV_ENC_RANGE_CHECK_EN.
- Defined: an accepted bundle is rejected (err pulse, no push) if its immediate does not fit the format:
  - I/S: imm[31:11] not all equal.
  - Shift: imm[11:5] != 0.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
- Undefined: no range checks; the immediate is silently truncated to the format bits; err fires only for an illegal opcode.

Test Plan:
- addi x1,x0,5 (op=0010011, f3=000, rd=1, rs1=0, imm=5), out_ready=1 -> instr=0x00500093, out_valid high 1 cycle after accept, enc_count=1.
- add x3,x1,x2 then sub (funct7b5=1), back-to-back -> instr 0x002081B3 then 0x402081B3 on consecutive cycles.
- beq x1,x2,-8 (op=1100011, rs1=1, rs2=2, imm=0xFFFFFFF8) -> 0xFE208CE3. jal x1,+2048 -> 0x001000EF.
- out_ready=0, push 4 bundles -> in_ready=0 after 4th accept. 5th held with in_valid=1. Raise out_ready -> 4 words popped in order, then 5th accepted; in_ready never high while full.
- op=0x7F -> err pulse, nothing pushed, enc_count unchanged. With RV_ENC_RANGE_CHECK_EN, addi imm=2048 -> err pulse, no push. Without the macro -> word 0x80000093 pushed.
- Reset asserted asynchronously with 2 queued words -> out_valid=0, instr=0, in_ready=1, enc_count=0 immediately. After release, the next push appears alone.
